// File: rtl/cu_decode_stage.sv
// rtl/cu_decode_stage.sv - decode-stage control unit with one-entry output register and multi-cycle interlock
// Optional illegal-encoding trap output enabled by CU_ILLEGAL_TRAP_EN.
module cu_decode_stage #(
    parameter int INSTR_W  = 32,
    parameter int MUL_LAT  = 2,
    parameter int TRIG_LAT = 4,
    parameter int LAT_W    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               pcSrc,
    output logic               regSrcA1,
    output logic               regSrcA2,
    output logic               immSrc,
    output logic               aluSrc,
    output logic               memWrite,
    output logic               memPixWrite,
    output logic               branch,
    output logic               bLink,
    output logic               regWrite,
    output logic               trigControl,
    output logic               flagWrite,
    output logic [3:0]         aluControl,
    output logic [1:0]         memToReg,
    output logic               mc_busy,
    output logic               illegal
);

    typedef struct packed {
        logic       pc_src;
        logic       reg_src_a1;
        logic       reg_src_a2;
        logic       imm_src;
        logic       alu_src;
        logic       mem_write;
        logic       mem_pix_write;
        logic       branch;
        logic       b_link;
        logic       reg_write;
        logic       trig_control;
        logic       flag_write;
        logic [3:0] alu_control;
        logic [1:0] mem_to_reg;
    } ctrl_t;

    logic [1:0] op;
    logic       imm;
    logic [4:0] cmd;
    logic       instr_unused;

    assign op           = instr[INSTR_W-1 -: 2];
    assign imm          = instr[INSTR_W-3];
    assign cmd          = instr[INSTR_W-4 -: 5];
    assign instr_unused = ^instr;

    ctrl_t            dec;
    logic             dec_illegal;
    logic [LAT_W-1:0] dec_lat;

    always_comb begin
        dec         = '0;
        dec_illegal = 1'b0;
        dec_lat     = '0;
        case (op)
            2'b00: begin
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = 2'b01;
                case (cmd)
                    5'd0:  begin dec.reg_write = 1'b0; dec.mem_to_reg = 2'b00; end
                    5'd1:  dec.alu_control = 4'b0101;
                    5'd2:  dec.alu_control = 4'b0100;
                    5'd3:  dec.alu_control = 4'b0001;
                    5'd4:  dec.alu_control = 4'b0010;
                    5'd5:  dec.alu_control = 4'b0011;
                    5'd6:  dec.alu_control = 4'b0000;
                    5'd7:  dec.alu_control = 4'b0111;
                    5'd8:  dec.alu_control = 4'b1000;
                    5'd9:  begin dec.alu_control = 4'b0110; dec_lat = LAT_W'(MUL_LAT - 1); end
                    5'd10: begin
                        dec.alu_control = 4'b0001;
                        dec.flag_write  = 1'b1;
                        dec.reg_write   = 1'b0;
                        dec.mem_to_reg  = 2'b00;
                    end
                    5'd11: begin dec.mem_to_reg = 2'b11; dec_lat = LAT_W'(TRIG_LAT - 1); end
                    5'd12: begin
                        dec.mem_to_reg   = 2'b11;
                        dec.trig_control = 1'b1;
                        dec_lat          = LAT_W'(TRIG_LAT - 1);
                    end
                    default: dec_illegal = 1'b1;
                endcase
                if (imm && cmd != 5'd0) begin
                    dec.alu_src = 1'b1;
                    dec.imm_src = 1'b0;
                end
            end
            2'b01: begin
                dec.alu_src     = 1'b1;
                dec.imm_src     = 1'b1;
                dec.alu_control = 4'b0010;
                case (cmd[1:0])
                    2'b00: dec.reg_write = 1'b1;
                    2'b01: begin dec.mem_write = 1'b1; dec.reg_src_a2 = 1'b1; end
                    2'b10: begin dec.reg_write = 1'b1; dec.mem_to_reg = 2'b10; end
                    default: begin dec.mem_pix_write = 1'b1; dec.reg_src_a2 = 1'b1; end
                endcase
            end
            2'b10: begin
                dec.pc_src     = 1'b1;
                dec.branch     = 1'b1;
                dec.imm_src    = 1'b1;
                dec.alu_src    = 1'b1;
                dec.reg_src_a1 = 1'b1;
                dec.b_link     = cmd[0];
                dec.reg_write  = cmd[0];
            end
            default: dec_illegal = 1'b1;
        endcase
        // Undefined encodings fall back to a plain NOP bundle.
        if (dec_illegal) begin
            dec     = '0;
            dec_lat = '0;
        end
    end

    ctrl_t            ctrl_q;
    logic [LAT_W-1:0] lat_q;
    logic [LAT_W-1:0] cnt;
    logic             accept;
    logic             consume;

    // A held multi-cycle op blocks issue so its successor cannot be accepted before the unit frees.
    assign in_ready = !flush && (cnt == '0) && (!out_valid || (out_ready && lat_q == '0));
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;
    assign mc_busy  = (cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q    <= '0;
            lat_q     <= '0;
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            if (accept) begin
                ctrl_q    <= dec;
                lat_q     <= dec_lat;
                out_valid <= 1'b1;
            end else if (consume || flush) begin
                out_valid <= 1'b0;
            end
            if (consume) begin
                cnt <= lat_q;
            end else if (cnt != '0) begin
                cnt <= cnt - LAT_W'(1);
            end
        end
    end

`ifdef CU_ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if (accept) begin
            illegal_q <= dec_illegal;
        end
    end
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign pcSrc       = ctrl_q.pc_src;
    assign regSrcA1    = ctrl_q.reg_src_a1;
    assign regSrcA2    = ctrl_q.reg_src_a2;
    assign immSrc      = ctrl_q.imm_src;
    assign aluSrc      = ctrl_q.alu_src;
    assign memWrite    = ctrl_q.mem_write;
    assign memPixWrite = ctrl_q.mem_pix_write;
    assign branch      = ctrl_q.branch;
    assign bLink       = ctrl_q.b_link;
    assign regWrite    = ctrl_q.reg_write;
    assign trigControl = ctrl_q.trig_control;
    assign flagWrite   = ctrl_q.flag_write;
    assign aluControl  = ctrl_q.alu_control;
    assign memToReg    = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_cu_decode_stage.sv
// tb/tb_cu_decode_stage.sv - directed self-checking bench for cu_decode_stage
module tb_cu_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic        pcSrc, regSrcA1, regSrcA2, immSrc, aluSrc, memWrite, memPixWrite;
    logic        branch, bLink, regWrite, trigControl, flagWrite, mc_busy, illegal;
    logic [3:0]  aluControl;
    logic [1:0]  memToReg;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cu_decode_stage #(.INSTR_W(32), .MUL_LAT(2), .TRIG_LAT(4), .LAT_W(3)) dut (
        .clk(clk), .rst(rst), .instr(instr), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .pcSrc(pcSrc), .regSrcA1(regSrcA1), .regSrcA2(regSrcA2), .immSrc(immSrc),
        .aluSrc(aluSrc), .memWrite(memWrite), .memPixWrite(memPixWrite), .branch(branch),
        .bLink(bLink), .regWrite(regWrite), .trigControl(trigControl), .flagWrite(flagWrite),
        .aluControl(aluControl), .memToReg(memToReg), .mc_busy(mc_busy), .illegal(illegal)
    );

    // {pc,a1,a2,immSrc,aluSrc,memW,pixW,branch,bLink,regW,trig,flagW, aluControl, memToReg}
    logic [17:0] bundle;
    assign bundle = {pcSrc, regSrcA1, regSrcA2, immSrc, aluSrc, memWrite, memPixWrite,
                     branch, bLink, regWrite, trigControl, flagWrite, aluControl, memToReg};

    localparam logic [17:0] B_NOP  = 18'b000000000000_0000_00;
    localparam logic [17:0] B_ADD  = 18'b000000000100_0010_01;
    localparam logic [17:0] B_ADDI = 18'b000010000100_0010_01;
    localparam logic [17:0] B_SUB  = 18'b000000000100_0001_01;
    localparam logic [17:0] B_LDR  = 18'b000110000100_0010_00;
    localparam logic [17:0] B_STR  = 18'b001111000000_0010_00;
    localparam logic [17:0] B_BL   = 18'b110110011100_0000_00;
    localparam logic [17:0] B_COS  = 18'b000000000110_0000_11;
    localparam logic [17:0] B_MUL  = 18'b000000000100_0110_01;

`ifdef CU_ILLEGAL_TRAP_EN
    localparam logic EXP_ILL = 1'b1;
`else
    localparam logic EXP_ILL = 1'b0;
`endif

    function automatic logic [31:0] mk(input logic [1:0] op, input logic im, input logic [4:0] cmd);
        return {op, im, cmd, 24'h0};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; instr = '0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_busy", {31'b0, mc_busy}, 0);
        check("rst_bundle", {14'b0, bundle}, {14'b0, B_NOP});
        check("rst_illegal", {31'b0, illegal}, 0);
        check("rst_in_ready", {31'b0, in_ready}, 1);

        // ADD without imm
        in_valid = 1'b1; out_ready = 1'b1; instr = mk(2'b00, 1'b0, 5'd4);
        tick();
        check("add_valid", {31'b0, out_valid}, 1);
        check("add_bundle", {14'b0, bundle}, {14'b0, B_ADD});

        instr = mk(2'b00, 1'b1, 5'd4);
        tick();
        check("addi_bundle", {14'b0, bundle}, {14'b0, B_ADDI});

        // back-to-back LDR, STR, BL
        instr = mk(2'b01, 1'b0, 5'd0);
        tick();
        check("ldr_bundle", {14'b0, bundle}, {14'b0, B_LDR});
        check("ldr_in_ready", {31'b0, in_ready}, 1);
        instr = mk(2'b01, 1'b0, 5'd1);
        tick();
        check("str_bundle", {14'b0, bundle}, {14'b0, B_STR});
        check("str_in_ready", {31'b0, in_ready}, 1);
        instr = mk(2'b10, 1'b0, 5'd1);
        tick();
        check("bl_bundle", {14'b0, bundle}, {14'b0, B_BL});
        check("bl_valid", {31'b0, out_valid}, 1);
        in_valid = 1'b0;
        tick();
        check("drain_valid", {31'b0, out_valid}, 0);

        // COS then ADD: consume at edge N, ADD accepted at N+4
        in_valid = 1'b1; instr = mk(2'b00, 1'b0, 5'd12);
        tick();
        check("cos_bundle", {14'b0, bundle}, {14'b0, B_COS});
        instr = mk(2'b00, 1'b0, 5'd4);
        #1;
        check("cos_held_in_ready", {31'b0, in_ready}, 0);
        tick();
        check("cos_n_busy", {31'b0, mc_busy}, 1);
        check("cos_n_valid", {31'b0, out_valid}, 0);
        tick();
        check("cos_n1_busy", {31'b0, mc_busy}, 1);
        tick();
        check("cos_n2_busy", {31'b0, mc_busy}, 1);
        check("cos_n2_in_ready", {31'b0, in_ready}, 0);
        tick();
        check("cos_n3_busy", {31'b0, mc_busy}, 0);
        check("cos_n3_in_ready", {31'b0, in_ready}, 1);
        check("cos_n3_valid", {31'b0, out_valid}, 0);
        tick();
        check("cos_n4_valid", {31'b0, out_valid}, 1);
        check("cos_n4_bundle", {14'b0, bundle}, {14'b0, B_ADD});

        // held SUB with out_ready low
        instr = mk(2'b00, 1'b0, 5'd3);
        tick();
        check("sub_bundle", {14'b0, bundle}, {14'b0, B_SUB});
        out_ready = 1'b0; instr = mk(2'b01, 1'b0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_in_ready", {31'b0, in_ready}, 0);
            tick();
            check("hold_bundle", {14'b0, bundle}, {14'b0, B_SUB});
            check("hold_valid", {31'b0, out_valid}, 1);
        end
        out_ready = 1'b1;
        #1;
        check("resume_in_ready", {31'b0, in_ready}, 1);
        tick();
        check("resume_bundle", {14'b0, bundle}, {14'b0, B_LDR});

        // flush of a held bundle
        out_ready = 1'b0; in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_held_valid", {31'b0, out_valid}, 0);

        // flush blocks accept in the same cycle
        in_valid = 1'b1; instr = mk(2'b00, 1'b0, 5'd9); flush = 1'b1;
        #1;
        check("flush_blocks_accept", {31'b0, in_ready}, 0);
        flush = 1'b0;
        tick();
        check("mul_bundle", {14'b0, bundle}, {14'b0, B_MUL});

        // flush together with MUL consume: counter still loads
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
        tick();
        check("mul_flush_valid", {31'b0, out_valid}, 0);
        check("mul_flush_busy", {31'b0, mc_busy}, 1);
        tick();
        flush = 1'b0;
        check("mul_busy_cleared", {31'b0, mc_busy}, 0);

        // illegal encodings
        in_valid = 1'b1; instr = mk(2'b11, 1'b0, 5'd0);
        tick();
        check("op11_valid", {31'b0, out_valid}, 1);
        check("op11_bundle", {14'b0, bundle}, {14'b0, B_NOP});
        check("op11_illegal", {31'b0, illegal}, {31'b0, EXP_ILL});
        instr = mk(2'b00, 1'b1, 5'd31);
        tick();
        check("cmd31_bundle", {14'b0, bundle}, {14'b0, B_NOP});
        check("cmd31_illegal", {31'b0, illegal}, {31'b0, EXP_ILL});
        instr = mk(2'b00, 1'b0, 5'd4);
        tick();
        check("legal_after_illegal", {31'b0, illegal}, 0);

        // reset mid-countdown
        instr = mk(2'b00, 1'b0, 5'd12);
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_busy", {31'b0, mc_busy}, 0);
        check("rst_mid_valid", {31'b0, out_valid}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
